// File: rtl/na_sweep_pkg.sv
// Shared definitions for the network-analyzer sweep sequencer.
// Holds the FSM encoding, bus register offsets and control/status bit positions.
// No logic, no latency, no flow control.
package na_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_WAIT = 3'd3,
    ST_PUSH = 3'd4,
    ST_NEXT = 3'd5
  } state_t;

  localparam logic [15:0] REG_CTRL   = 16'h0000;
  localparam logic [15:0] REG_START  = 16'h0004;
  localparam logic [15:0] REG_STEP   = 16'h0008;
  localparam logic [15:0] REG_NPTS   = 16'h000C;
  localparam logic [15:0] REG_STATUS = 16'h0010;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CONT  = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ABORTED   = 2;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_IDX_LSB   = 16;

endpackage

// File: rtl/na_sweep_regs.sv
// Bus register file for the sweep sequencer: config registers, status read mux, start/abort strobes.
// Latency: ack/rdata one cycle after wen/ren; start/abort strobes are combinational from the write.
// Backpressure: none, every bus access is acknowledged on the next cycle.
// Ports: clk/rst; bus addr/wen/ren/wdata -> ack/rdata; config outputs start_freq/step_freq/npoints/cont;
//        strobes start/abort; status inputs busy/done/aborted/state/idx from the sequencer FSM.
module na_sweep_regs
  import na_sweep_pkg::*;
#(
  parameter int PHASEBITS = 32,
  parameter int IDXBITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata,
  output logic [PHASEBITS-1:0] start_freq,
  output logic [PHASEBITS-1:0] step_freq,
  output logic [IDXBITS-1:0]   npoints,
  output logic                 cont,
  output logic                 start,
  output logic                 abort,
  input  logic                 busy,
  input  logic                 done,
  input  logic                 aborted,
  input  state_t               state,
  input  logic [15:0]          idx
);

  logic        ctrl_wr;
  logic [31:0] status;
  logic [31:0] rd_mux;

  // Strobes are decoded straight from the bus so the FSM acts on the cycle after the write.
  assign ctrl_wr = wen && (addr == REG_CTRL);
  assign start   = ctrl_wr && wdata[CTRL_START];
  assign abort   = ctrl_wr && wdata[CTRL_ABORT];

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = busy;
    status[STAT_DONE]               = done;
    status[STAT_ABORTED]            = aborted;
    status[STAT_STATE_LSB +: 4]     = 4'(state);
    status[STAT_IDX_LSB +: 16]      = idx;
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      REG_CTRL:   rd_mux[CTRL_CONT] = cont;
      REG_START:  rd_mux = 32'(start_freq);
      REG_STEP:   rd_mux = 32'(step_freq);
      REG_NPTS:   rd_mux = 32'(npoints);
      REG_STATUS: rd_mux = status;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack        <= 1'b0;
      rdata      <= '0;
      start_freq <= '0;
      step_freq  <= '0;
      npoints    <= '0;
      cont       <= 1'b0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_mux : '0;
      if (ctrl_wr)                     cont       <= wdata[CTRL_CONT];
      // Config writes land here at any time; the sequencer only samples them at start.
      if (wen && addr == REG_START)    start_freq <= PHASEBITS'(wdata);
      if (wen && addr == REG_STEP)     step_freq  <= PHASEBITS'(wdata);
      if (wen && addr == REG_NPTS)     npoints    <= IDXBITS'(wdata);
    end
  end

endmodule

// File: rtl/na_sweep_sequencer.sv
// Steps an IQ block through npoints frequencies and streams the I/Q sums of each point.
// Latency: freq write pulse 1 cycle after start; record valid 1 cycle after averaging ends.
// Backpressure: a record is held stable until res_ready_i; the sweep stalls meanwhile.
// Ports: clk_i/rst_i; system bus addr/wen/ren/wdata/ack/rdata; IQ side iq_freq_o/iq_freq_we_o,
//        iq_avg_i, iq_i_sum_i/iq_q_sum_i; result stream res_valid_o/res_ready_i with res_i_o,
//        res_q_o, res_idx_o, res_last_o.
module na_sweep_sequencer
  import na_sweep_pkg::*;
#(
  parameter int PHASEBITS = 32,
  parameter int SUMBITS   = 62,
  parameter int IDXBITS   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata,
  output logic [PHASEBITS-1:0] iq_freq_o,
  output logic                 iq_freq_we_o,
  input  logic                 iq_avg_i,
  input  logic [SUMBITS-1:0]   iq_i_sum_i,
  input  logic [SUMBITS-1:0]   iq_q_sum_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [SUMBITS-1:0]   res_i_o,
  output logic [SUMBITS-1:0]   res_q_o,
  output logic [IDXBITS-1:0]   res_idx_o,
  output logic                 res_last_o
);

  localparam logic [IDXBITS-1:0] IDX_ONE = IDXBITS'(1);

  state_t               state;
  logic [PHASEBITS-1:0] reg_start, reg_step, cfg_start, cfg_step;
  logic [IDXBITS-1:0]   reg_npts, cfg_npts, idx;
  logic                 cont, start, abort, done, aborted, busy;

  assign busy = (state != ST_IDLE);

  na_sweep_regs #(
    .PHASEBITS(PHASEBITS),
    .IDXBITS  (IDXBITS)
  ) u_regs (
    .clk       (clk_i),
    .rst       (rst_i),
    .addr      (addr),
    .wen       (wen),
    .ren       (ren),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .start_freq(reg_start),
    .step_freq (reg_step),
    .npoints   (reg_npts),
    .cont      (cont),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .state     (state),
    .idx       (16'(idx))
  );

  // iq_freq_o doubles as the running frequency register of the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cfg_start    <= '0;
      cfg_step     <= '0;
      cfg_npts     <= '0;
      idx          <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      iq_freq_o    <= '0;
      iq_freq_we_o <= 1'b0;
      res_valid_o  <= 1'b0;
      res_i_o      <= '0;
      res_q_o      <= '0;
      res_idx_o    <= '0;
      res_last_o   <= 1'b0;
    end else begin
      iq_freq_we_o <= 1'b0;
      if (abort) begin
        // Abort wins over everything, including a start in the same write.
        state       <= ST_IDLE;
        res_valid_o <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              aborted <= 1'b0;
              if (reg_npts == '0) begin
                done <= 1'b1;
              end else begin
                done         <= 1'b0;
                cfg_start    <= reg_start;
                cfg_step     <= reg_step;
                cfg_npts     <= reg_npts;
                idx          <= '0;
                iq_freq_o    <= reg_start;
                iq_freq_we_o <= 1'b1;
                state        <= ST_LOAD;
              end
            end
          end
          ST_LOAD: state <= ST_ARM;
          ST_ARM: begin
            if (iq_avg_i) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!iq_avg_i) begin
              res_i_o     <= iq_i_sum_i;
              res_q_o     <= iq_q_sum_i;
              res_idx_o   <= idx;
              res_last_o  <= (idx == cfg_npts - IDX_ONE);
              res_valid_o <= 1'b1;
              state       <= ST_PUSH;
            end
          end
          ST_PUSH: begin
            if (res_ready_i) begin
              res_valid_o <= 1'b0;
              if (!res_last_o) begin
                state <= ST_NEXT;
              end else if (cont) begin
                // Continuous mode reads the live control bit so clearing it ends after this pass.
                idx          <= '0;
                iq_freq_o    <= cfg_start;
                iq_freq_we_o <= 1'b1;
                state        <= ST_LOAD;
              end else begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
          ST_NEXT: begin
            idx          <= idx + IDX_ONE;
            iq_freq_o    <= iq_freq_o + cfg_step;
            iq_freq_we_o <= 1'b1;
            state        <= ST_LOAD;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_na_sweep_sequencer.sv
// Directed bench for na_sweep_sequencer with a behavioural IQ averaging model.
// Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
// Records and frequency pulses are logged to queues and compared with hand-derived values.
module tb_na_sweep_sequencer;

  localparam int AVG = 10;

  typedef struct packed {
    logic [15:0] idx;
    logic        last;
    logic [61:0] i;
    logic [61:0] q;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] iq_freq;
  logic        iq_freq_we;
  logic        iq_avg = 1'b0;
  logic [61:0] iq_i_sum = '0;
  logic [61:0] iq_q_sum = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [61:0] res_i;
  logic [61:0] res_q;
  logic [15:0] res_idx;
  logic        res_last;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] fq[$];
  int          we_cyc[$];
  int          hs_cyc[$];
  rec_t        rq[$];

  logic        hold_en = 1'b0;
  logic        pv = 1'b0, pr = 1'b0, p_last = 1'b0;
  logic [61:0] p_i = '0, p_q = '0;
  logic [15:0] p_idx = '0;

  logic [31:0] m_freq = '0;
  int          m_cnt = 0;

  na_sweep_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr        (addr),
    .wen         (wen),
    .ren         (ren),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .iq_freq_o   (iq_freq),
    .iq_freq_we_o(iq_freq_we),
    .iq_avg_i    (iq_avg),
    .iq_i_sum_i  (iq_i_sum),
    .iq_q_sum_i  (iq_q_sum),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_i_o     (res_i),
    .res_q_o     (res_q),
    .res_idx_o   (res_idx),
    .res_last_o  (res_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [61:0] exp_i(input logic [31:0] f);
    return ({30'd0, f} << 20) | 62'h5;
  endfunction

  function automatic logic [61:0] exp_q(input logic [31:0] f);
    return ~{30'd0, f};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // IQ block model: averaging starts the cycle after a freq write and lasts AVG cycles;
  // sums carry junk while averaging and a frequency-dependent final value afterwards.
  always @(posedge clk) begin
    if (iq_freq_we) begin
      m_freq   <= iq_freq;
      m_cnt    <= AVG - 1;
      iq_avg   <= 1'b1;
      iq_i_sum <= 62'h3;
      iq_q_sum <= 62'h3;
    end else if (iq_avg) begin
      if (m_cnt == 0) begin
        iq_avg   <= 1'b0;
        iq_i_sum <= exp_i(m_freq);
        iq_q_sum <= exp_q(m_freq);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (iq_freq_we) begin
      fq.push_back(iq_freq);
      we_cyc.push_back(cyc);
    end
    if (res_valid && res_ready) begin
      rq.push_back('{idx: res_idx, last: res_last, i: res_i, q: res_q});
      hs_cyc.push_back(cyc);
    end
    if (hold_en && pv && !pr) begin
      check("hold_vld", res_valid, 1);
      check("hold_dat", {res_idx, res_last, res_i[46:0]}, {p_idx, p_last, p_i[46:0]});
      check("hold_q", res_q, p_q);
    end
    pv = res_valid; pr = res_ready;
    p_i = res_i; p_q = res_q; p_idx = res_idx; p_last = res_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    tick();
    d = rdata;
    ren = 1'b0;
  endtask

  task automatic clr_q();
    fq.delete(); we_cyc.delete(); hs_cyc.delete(); rq.delete();
  endtask

  task automatic wait_recs(input string tag, input int n);
    int b = 0;
    while (rq.size() < n && b < 1000) begin tick(); b++; end
    check({tag, "_wait"}, rq.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s = 32'h1;
    int b = 0;
    while (s[0] && b < 200) begin bus_rd(16'h0010, s); b++; end
    check({tag, "_idle"}, s[0], 0);
  endtask

  task automatic wait_valid(input string tag);
    int b = 0;
    while (!res_valid && b < 200) begin tick(); b++; end
    check({tag, "_vld"}, res_valid, 1);
  endtask

  task automatic check_recs(input string tag, input int n, input logic [31:0] f0,
                            input logic [31:0] step, input int period);
    logic [31:0] f;
    int k;
    check({tag, "_nrec"}, rq.size(), n);
    check({tag, "_nwe"}, fq.size(), n);
    for (int i = 0; i < n && i < rq.size() && i < fq.size(); i++) begin
      k = i % period;
      f = f0 + step * k;
      check($sformatf("%s_f%0d", tag, i), fq[i], f);
      check($sformatf("%s_idx%0d", tag, i), rq[i].idx, k);
      check($sformatf("%s_last%0d", tag, i), rq[i].last, (k == period - 1));
      check($sformatf("%s_i%0d", tag, i), rq[i].i, exp_i(f));
      check($sformatf("%s_q%0d", tag, i), rq[i].q, exp_q(f));
    end
  endtask

  initial begin
    logic [31:0] s;

    // Reset state
    repeat (3) tick();
    check("rst_vld", res_valid, 0);
    check("rst_we", iq_freq_we, 0);
    check("rst_freq", iq_freq, 0);
    check("rst_last", res_last, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();
    bus_rd(16'h0010, s);
    check("rst_status", s, 0);
    check("ack_rd", ack, 1);
    tick();
    check("ack_drop", ack, 0);

    // Basic sweep, plus start-while-busy and config-write-while-busy
    bus_wr(16'h0004, 32'h1000);
    bus_wr(16'h0008, 32'h100);
    bus_wr(16'h000C, 32'd3);
    bus_rd(16'h0008, s);
    check("rd_step", s, 32'h100);
    bus_rd(16'h0020, s);
    check("unmapped", s, 0);
    res_ready = 1'b1;
    clr_q();
    bus_wr(16'h0000, 32'h1);
    check("start_we", iq_freq_we, 1);
    check("start_freq", iq_freq, 32'h1000);
    tick();
    check("we_1cyc", iq_freq_we, 0);
    repeat (4) tick();
    bus_wr(16'h0000, 32'h1);
    bus_wr(16'h0004, 32'h7000);
    wait_recs("basic", 3);
    wait_idle("basic");
    check_recs("basic", 3, 32'h1000, 32'h100, 3);
    if (we_cyc.size() > 1 && hs_cyc.size() > 0)
      check("hs2we", we_cyc[1] - hs_cyc[0], 2);
    bus_rd(16'h0010, s);
    check("basic_status", s, 32'h0002_0002);
    bus_rd(16'h0004, s);
    check("busy_cfg_wr", s, 32'h7000);

    // Same sweep with the sink stalling 20 cycles on every record
    bus_wr(16'h0004, 32'h1000);
    res_ready = 1'b0;
    clr_q();
    bus_wr(16'h0000, 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_valid("stall");
      hold_en = 1'b1;
      repeat (20) tick();
      check("stall_nowe", fq.size(), k + 1);
      check("stall_vld_held", res_valid, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    hold_en = 1'b0;
    wait_idle("stall");
    check_recs("stall", 3, 32'h1000, 32'h100, 3);

    // Frequency wrap
    bus_wr(16'h0004, 32'hFFFF_FF80);
    bus_wr(16'h000C, 32'd2);
    res_ready = 1'b1;
    clr_q();
    bus_wr(16'h0000, 32'h1);
    wait_recs("wrap", 2);
    wait_idle("wrap");
    check_recs("wrap", 2, 32'hFFFF_FF80, 32'h100, 2);
    if (fq.size() > 1) check("wrap_f1", fq[1], 32'h0000_0080);
    bus_rd(16'h0010, s);
    check("wrap_status", s, 32'h0001_0002);

    // Abort while waiting on point 1
    bus_wr(16'h0004, 32'h2000);
    bus_wr(16'h0008, 32'h10);
    bus_wr(16'h000C, 32'd3);
    clr_q();
    bus_wr(16'h0000, 32'h1);
    for (int b = 0; b < 200 && fq.size() < 2; b++) tick();
    repeat (3) tick();
    bus_wr(16'h0000, 32'h2);
    bus_rd(16'h0010, s);
    check("abort_status", s, 32'h0001_0004);
    check("abort_vld", res_valid, 0);
    repeat (30) tick();
    check("abort_nrec", rq.size(), 1);
    check("abort_nwe", fq.size(), 2);

    // Zero-point start
    bus_wr(16'h000C, 32'd0);
    clr_q();
    bus_wr(16'h0000, 32'h1);
    check("npts0_we", iq_freq_we, 0);
    repeat (5) tick();
    check("npts0_nwe", fq.size(), 0);
    bus_rd(16'h0010, s);
    check("npts0_status", s & 32'hF3, 32'h02);

    // Fresh sweep after the abort starts from index 0
    bus_wr(16'h000C, 32'd3);
    clr_q();
    bus_wr(16'h0000, 32'h1);
    wait_recs("fresh", 3);
    wait_idle("fresh");
    check_recs("fresh", 3, 32'h2000, 32'h10, 3);
    bus_rd(16'h0010, s);
    check("fresh_status", s, 32'h0002_0002);

    // Continuous mode, then clear continuous to finish the current pass
    bus_wr(16'h0004, 32'h3000);
    bus_wr(16'h0008, 32'h40);
    bus_wr(16'h000C, 32'd2);
    clr_q();
    bus_wr(16'h0000, 32'h5);
    wait_recs("cont", 5);
    bus_wr(16'h0000, 32'h0);
    wait_idle("cont");
    check_recs("cont", 6, 32'h3000, 32'h40, 2);
    bus_rd(16'h0010, s);
    check("cont_status", s, 32'h0001_0002);

    // Reset while a record is waiting on the sink
    res_ready = 1'b0;
    clr_q();
    bus_wr(16'h0000, 32'h1);
    wait_valid("rstpush");
    rst = 1'b1;
    tick();
    check("rstpush_vld", res_valid, 0);
    check("rstpush_freq", iq_freq, 0);
    check("rstpush_i", res_i, 0);
    rst = 1'b0;
    bus_rd(16'h0010, s);
    check("rstpush_status", s, 0);
    bus_rd(16'h0004, s);
    check("rstpush_start", s, 0);
    bus_rd(16'h000C, s);
    check("rstpush_npts", s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/na_sweep_sequencer.md
# na_sweep_sequencer

Controller that runs a network-analyzer frequency sweep on one IQ block. It steps the IQ phase increment through `npoints` values, starting at `start_freq` and adding `step_freq` each point. For each point it waits for that block's averaging cycle to finish, then delivers the I/Q sums as one record on a valid/ready result stream. It sits between the PS system bus and the IQ block's frequency-write/averaging interface, so the CPU no longer has to handshake every point.

## Interface
Parameters:
- `PHASEBITS`, 32, width of frequency / phase increment
- `SUMBITS`, 62, width of I and Q accumulator sums
- `IDXBITS`, 16, width of point counter

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `addr`  in  16  system bus address
- `wen`  in  1  bus write strobe
- `ren`  in  1  bus read strobe
- `wdata`  in  32  bus write data
- `ack`  out  1  bus acknowledge
- `rdata`  out  32  bus read data
- `iq_freq_o`  out  PHASEBITS  frequency word for the IQ block
- `iq_freq_we_o`  out  1  one-cycle write pulse; restarts IQ averaging
- `iq_avg_i`  in  1  IQ averaging-in-progress flag
- `iq_i_sum_i`  in  SUMBITS  IQ I accumulator
- `iq_q_sum_i`  in  SUMBITS  IQ Q accumulator
- `res_valid_o`  out  1  result record valid
- `res_ready_i`  in  1  sink ready
- `res_i_o`  out  SUMBITS  captured I sum
- `res_q_o`  out  SUMBITS  captured Q sum
- `res_idx_o`  out  IDXBITS  point index
- `res_last_o`  out  1  final point of the sweep

## Operation
Registers:
- 0x00 control (write): bit0 start (self-clearing), bit1 abort (self-clearing), bit2 continuous (held)
- 0x04 `start_freq`
- 0x08 `step_freq`
- 0x0C `npoints` (IDXBITS)
- 0x10 status (read-only): bit0 busy, bit1 done (sticky), bit2 aborted (sticky), bits[7:4] state, bits[31:16] current index
- Unmapped reads return 0.
- `ack` = registered `wen|ren`.
- Writes to 0x04/0x08/0x0C while busy are accepted but only take effect at the next start.

FSM states: IDLE(0), LOAD(1), ARM(2), WAIT(3), PUSH(4), NEXT(5).
- IDLE → LOAD on start with `npoints`≠0. This latches the configuration, sets freq=`start_freq`, idx=0, and clears done/aborted.
- Start with `npoints`=0: no sweep; done is set directly.
- LOAD: pulse `iq_freq_we_o` with `iq_freq_o`=freq → ARM.
- ARM: wait for `iq_avg_i`=1 → WAIT.
- WAIT: on `iq_avg_i`=0, capture both sums, idx and last (idx==`npoints`−1) → PUSH.
- PUSH: hold `res_valid_o` and the data stable until `res_ready_i`.
  - On handshake, if last: go to LOAD with a restart if continuous, otherwise IDLE with done set.
  - On handshake, if not last: → NEXT.
- NEXT: freq += `step_freq` modulo 2^PHASEBITS; idx += 1 → LOAD.
- Continuous restart: freq reloads to `start_freq`, idx reloads to 0.

Abort:
- Effective in any state on the cycle after the write.
- Goes to IDLE, drops `res_valid_o` and sets aborted.
- Abort overrides a simultaneous start.
- Start while busy is ignored.

Reset values:
- All registers 0, state IDLE.
- `ack`, `rdata`, `iq_freq_we_o`, `res_valid_o`, `res_last_o` are 0.
- `iq_freq_o`, `res_*` data outputs are 0.

## Timing
- Start write at cycle t: LOAD at t+1, and `iq_freq_we_o`=1 during t+1 only.
- ARM at t+2; the IQ block raises `iq_avg_i` one cycle after the write pulse.
- Sums are sampled in the first WAIT cycle where `iq_avg_i`=0 and are presented in PUSH on the next cycle.
- Back-to-back points with `res_ready_i`=1: the PUSH handshake is followed by NEXT, then LOAD. The next `iq_freq_we_o` fires 2 cycles after the handshake.
- Records are never dropped or duplicated. Data is unchanged while valid and not ready.
- Reset mid-sweep returns to IDLE on the next clock and clears the sticky bits.

## Structure
- Shared package holds:
  - the state encoding
  - the register offsets 0x00–0x10
  - the control/status bit positions
- One sub-module is natural: `na_sweep_regs`. It provides the bus decode, the config/status registers, and the start/abort pulses.
- The FSM and datapath live in the top module.

## Test plan
- start_freq=0x1000, step=0x100, npoints=3, ready=1, IQ model with averaging 10 cycles:
  - three `iq_freq_we_o` pulses with 0x1000, 0x1100, 0x1200
  - three records idx 0,1,2, last only on idx 2
  - done=1, busy=0
- Same sweep with `res_ready_i` low for 20 cycles during each PUSH → valid held, data stable, no extra freq write until the handshake.
- start_freq=0xFFFFFF80, step=0x100, npoints=2 → second freq 0x00000080 (wrap).
- Abort written while in WAIT at point 1 → IDLE next cycle, aborted=1, no further records; a subsequent start runs a fresh sweep from idx 0.
- Continuous=1, npoints=2 → idx sequence 0,1,0,1…, freq reloads to start_freq; clearing continuous ends the sweep after the current last point with done=1.
- Edge cases:
  - npoints=0 start → done=1, no pulse.
  - start while busy → ignored.
  - `rst_i` mid-PUSH → `res_valid_o`=0 next cycle, all registers 0.
